// File: rtl/demux_dispatcher_if.sv
// Handshake bundle between the operand source, the dispatcher and its N_CH consumers.
// The slave side is the dispatcher. The master side is the source together with the consumers.
interface demux_dispatcher_if #(
    parameter int WIDTH = 16,
    parameter int N_CH  = 6,
    parameter int SEL_W = 3,
    parameter int CNT_W = 8
);
    logic [SEL_W-1:0]      op;
    logic                  broadcast;
    logic [WIDTH-1:0]      entrada;
    logic                  entrada_valid;
    logic                  entrada_ready;
    logic [N_CH*WIDTH-1:0] saida;
    logic [N_CH-1:0]       saida_valid;
    logic [N_CH-1:0]       saida_ready;
    logic                  erro;
    logic [CNT_W-1:0]      drop_count;

    modport slave (
        input  op, broadcast, entrada, entrada_valid, saida_ready,
        output entrada_ready, saida, saida_valid, erro, drop_count
    );

    modport master (
        output op, broadcast, entrada, entrada_valid, saida_ready,
        input  entrada_ready, saida, saida_valid, erro, drop_count
    );
endinterface

// File: rtl/demux_dispatcher.sv
// Registered 1-to-N operand demux. Each channel has a one-entry slot, so a stalled consumer
// blocks only the traffic addressed to it. Also provides broadcast and drop accounting for bad selects.
module demux_dispatcher #(
    parameter int WIDTH = 16,
    parameter int N_CH  = 6,
    parameter int SEL_W = 3,
    parameter int CNT_W = 8
) (
    input  logic clock,
    input  logic reset,
    demux_dispatcher_if.slave bus
);
    localparam logic [SEL_W:0] N_CH_L = (SEL_W+1)'(N_CH);

    logic [N_CH-1:0][WIDTH-1:0] data_q, data_d;
    logic [N_CH-1:0]            valid_q, valid_d;
    logic                       erro_q, erro_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;

    logic [N_CH-1:0] free, load;
    logic            out_of_range, sel_free, ready, xfer;

    always_comb begin
        free         = ~valid_q | bus.saida_ready;
        out_of_range = !bus.broadcast && ({1'b0, bus.op} >= N_CH_L);
        sel_free     = 1'b0;
        for (int i = 0; i < N_CH; i++)
            if (bus.op == SEL_W'(i)) sel_free = free[i];

        if (bus.broadcast)   ready = &free;
        else if (out_of_range) ready = 1'b1;
        else                 ready = sel_free;

        xfer = bus.entrada_valid && ready;

        for (int i = 0; i < N_CH; i++)
            load[i] = xfer && (bus.broadcast || (!out_of_range && bus.op == SEL_W'(i)));

        // A reload on the same edge as a drain keeps the slot valid, giving one transfer per cycle per channel.
        valid_d = load | (valid_q & ~bus.saida_ready);
        data_d  = data_q;
        for (int i = 0; i < N_CH; i++)
            if (load[i]) data_d[i] = bus.entrada;

        erro_d = xfer && out_of_range;
        cnt_d  = cnt_q;
        if (erro_d && cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= '0;
            erro_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            erro_q  <= erro_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.entrada_ready = ready;
    assign bus.saida         = data_q;
    assign bus.saida_valid   = valid_q;
    assign bus.erro          = erro_q;
    assign bus.drop_count    = cnt_q;
endmodule

// File: tb/tb_demux_dispatcher.sv
// Self-checking bench for demux_dispatcher. It runs directed scenarios and a random phase.
// Every cycle is compared against a per-channel slot model built from the handshake rules.
module tb_demux_dispatcher;
    localparam int W = 16, N = 6, S = 3, C = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    demux_dispatcher_if #(.WIDTH(W), .N_CH(N), .SEL_W(S), .CNT_W(C)) bus ();
    demux_dispatcher #(.WIDTH(W), .N_CH(N), .SEL_W(S), .CNT_W(C)) dut (
        .clock(clock), .reset(reset), .bus(bus)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: one occupancy flag and one data word per channel, plus the drop accounting.
    bit        m_valid [N];
    bit [W-1:0] m_data [N];
    bit        m_erro;
    int        m_cnt;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic bit exp_ready(input bit bc, input int o, input logic [N-1:0] r);
        bit all_free = 1'b1;
        for (int i = 0; i < N; i++) if (m_valid[i] && !r[i]) all_free = 1'b0;
        if (bc) return all_free;
        if (o >= N) return 1'b1;
        return !m_valid[o] || r[o];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin m_valid[i] = 0; m_data[i] = '0; end
        m_erro = 0;
        m_cnt  = 0;
    endtask

    task automatic check_outputs(input string tag);
        logic [N*W-1:0] ed;
        logic [N-1:0]   ev;
        for (int i = 0; i < N; i++) begin
            ed[i*W +: W] = m_data[i];
            ev[i] = m_valid[i];
        end
        chk({tag, ".saida_valid"}, 128'(bus.saida_valid), 128'(ev));
        chk({tag, ".saida"},       128'(bus.saida),       128'(ed));
        chk({tag, ".erro"},        128'(bus.erro),        128'(m_erro));
        chk({tag, ".drop_count"},  128'(bus.drop_count),  128'(m_cnt));
    endtask

    // One clock cycle: drive the inputs, check entrada_ready, advance the model across the edge,
    // then check the registered outputs.
    task automatic step(input string tag, input bit v, input bit bc, input int o,
                        input logic [W-1:0] d, input logic [N-1:0] r, output bit acc);
        bit er, oor;
        bus.entrada_valid = v;
        bus.broadcast     = bc;
        bus.op            = S'(o);
        bus.entrada       = d;
        bus.saida_ready   = r;
        #1;
        er = exp_ready(bc, o, r);
        chk({tag, ".entrada_ready"}, 128'(bus.entrada_ready), 128'(er));
        acc = v && er;
        oor = !bc && o >= N;
        @(posedge clock);
        for (int i = 0; i < N; i++) begin
            if (acc && (bc || (!oor && o == i))) begin
                m_valid[i] = 1;
                m_data[i]  = d;
            end else if (m_valid[i] && r[i]) begin
                m_valid[i] = 0;
            end
        end
        m_erro = acc && oor;
        if (m_erro && m_cnt < 255) m_cnt++;
        #1;
        check_outputs(tag);
    endtask

    task automatic do_reset(input string tag);
        bus.entrada_valid = 1'b0;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_clear();
        check_outputs(tag);
    endtask

    bit acc;
    bit p_v, p_bc;
    int p_op;
    logic [W-1:0] p_d;
    logic [W-1:0] sweep_d [N] = '{16'd1, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5};

    initial begin
        bus.entrada_valid = 0; bus.broadcast = 0; bus.op = '0;
        bus.entrada = '0; bus.saida_ready = '0;
        model_clear();
        @(posedge clock); #1;
        do_reset("reset");
        step("idle", 0, 0, 0, 16'h0, 6'h00, acc);

        // Unicast sweep with every consumer ready
        for (int i = 0; i < N; i++) step("sweep", 1, 0, i, sweep_d[i], 6'h3F, acc);
        step("sweep_tail", 0, 0, 0, 16'h0, 6'h3F, acc);

        // Backpressure on channel 2
        step("bp_load7", 1, 0, 2, 16'd7, 6'b111011, acc);
        for (int k = 0; k < 3; k++) step("bp_stall9", 1, 0, 2, 16'd9, 6'b111011, acc);
        step("bp_op3", 1, 0, 3, 16'd4, 6'b111011, acc);
        step("bp_reload9", 1, 0, 2, 16'd9, 6'b111111, acc);
        step("bp_drain", 0, 0, 0, 16'h0, 6'h3F, acc);

        // Broadcast into empty channels, then a blocked broadcast with channel 5 full
        step("bc_load", 1, 1, 3, 16'h00A5, 6'b011111, acc);
        for (int k = 0; k < 2; k++) step("bc_block", 1, 1, 0, 16'h005A, 6'b011111, acc);
        step("bc_drain", 0, 0, 0, 16'h0, 6'h3F, acc);

        // Out-of-range selects, then counter saturation
        step("inv_op6", 1, 0, 6, 16'd8, 6'h3F, acc);
        step("inv_op7", 1, 0, 7, 16'd8, 6'h3F, acc);
        step("inv_gap", 0, 0, 7, 16'd8, 6'h3F, acc);
        for (int k = 0; k < 300; k++)
            step("inv_sat", 1, 0, 6 + (k % 2), 16'($urandom), 6'($urandom), acc);

        // Random traffic. Inputs are held stable while a transfer is stalled.
        do_reset("reset2");
        p_v = 0; p_bc = 0; p_op = 0; p_d = '0;
        for (int k = 0; k < 400; k++) begin
            if (!(p_v && !acc)) begin
                p_v  = ($urandom_range(0, 3) != 0);
                p_bc = ($urandom_range(0, 7) == 0);
                p_op = $urandom_range(0, 7);
                p_d  = 16'($urandom);
            end
            step("rand", p_v, p_bc, p_op, p_d, 6'($urandom), acc);
        end

        // Reset mid-operation: three channels full and drop_count at 5
        do_reset("reset3");
        for (int k = 0; k < 5; k++) step("mid_inv", 1, 0, 6, 16'h1234, 6'h00, acc);
        step("mid_ld0", 1, 0, 0, 16'hAAAA, 6'h00, acc);
        step("mid_ld1", 1, 0, 1, 16'hBBBB, 6'h00, acc);
        step("mid_ld4", 1, 0, 4, 16'hCCCC, 6'h00, acc);
        do_reset("mid_reset");
        step("post_reset", 0, 0, 0, 16'h0, 6'h3F, acc);
        step("post_reset2", 0, 0, 0, 16'h0, 6'h00, acc);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
